// File: rtl/mlp.sv
// mlp: register-mapped two-layer ReLU perceptron, one shared multiplier; MLP_IRQ_EN enables the completion interrupt
module mlp #(
  parameter int N_INPUTS  = 2,
  parameter int N_HIDDEN  = 4,
  parameter int N_OUTPUT  = 1,
  parameter int IN_WIDTH  = 16,
  parameter int WGT_WIDTH = 16,
  parameter int MAC_WIDTH = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic [1:0]  addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  localparam int HW_N = N_HIDDEN * (N_INPUTS + 1);
  localparam int OW_N = N_OUTPUT * (N_HIDDEN + 1);
  localparam int IA   = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
  localparam int HA   = N_HIDDEN > 1 ? $clog2(N_HIDDEN) : 1;
  localparam int OA   = N_OUTPUT > 1 ? $clog2(N_OUTPUT) : 1;
  localparam int HWA  = HW_N > 1 ? $clog2(HW_N) : 1;
  localparam int OWA  = OW_N > 1 ? $clog2(OW_N) : 1;
  localparam int PW   = HWA > OWA ? HWA : OWA;
  localparam int NC   = HA > OA ? HA : OA;
  localparam int KM   = N_INPUTS > N_HIDDEN ? N_INPUTS : N_HIDDEN;
  localparam int SC   = $clog2(KM + 2);
  localparam int XW   = IN_WIDTH > OUT_WIDTH ? IN_WIDTH : OUT_WIDTH;
  localparam int PRW  = WGT_WIDTH + XW;
  typedef enum logic [1:0] {IDLE, HID, OUT, FIN} state_t;
  state_t state;
  logic done, ie, lsel, busy, hid, active, last_n;
  logic [IA-1:0] in_ptr;
  logic [PW-1:0] w_ptr;
  logic [OA-1:0] out_idx;
  logic [NC-1:0] nrn;
  logic [SC-1:0] step, kk, tap;
  logic [HWA-1:0] hidx;
  logic [OWA-1:0] oidx;
  logic signed [IN_WIDTH-1:0]  in_mem [N_INPUTS];
  logic signed [WGT_WIDTH-1:0] hid_w [HW_N];
  logic signed [WGT_WIDTH-1:0] out_w [OW_N];
  logic signed [OUT_WIDTH-1:0] act [N_HIDDEN];
  logic signed [OUT_WIDTH-1:0] res [N_OUTPUT];
  logic signed [WGT_WIDTH-1:0] wsel;
  logic signed [XW-1:0]        xsel;
  logic signed [PRW-1:0]       prod;
  logic signed [MAC_WIDTH-1:0] acc, prod_ext;
  logic signed [OUT_WIDTH-1:0] y;
  // operand selection for the single multiplier and the saturating ReLU of the accumulator
  always_comb begin
    hid      = state == HID;
    active   = state != IDLE;
    kk       = hid ? SC'(N_INPUTS) : SC'(N_HIDDEN);
    tap      = (step != '0 && step <= kk) ? step - SC'(1) : '0;
    hidx     = (hid && step <= kk) ? HWA'(int'(nrn) * (N_INPUTS + 1) + int'(step)) : '0;
    oidx     = (!hid && step <= kk) ? OWA'(int'(nrn) * (N_HIDDEN + 1) + int'(step)) : '0;
    wsel     = hid ? hid_w[hidx] : out_w[oidx];
    xsel     = hid ? XW'(in_mem[IA'(tap)]) : XW'(act[HA'(tap)]);
    prod     = wsel * xsel;
    prod_ext = MAC_WIDTH'(prod);
    y        = acc[MAC_WIDTH-1] ? '0 : (|acc[MAC_WIDTH-2:OUT_WIDTH-1]) ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : acc[OUT_WIDTH-1:0];
    last_n   = nrn == (hid ? NC'(N_HIDDEN - 1) : NC'(N_OUTPUT - 1));
  end
  // host register writes and the neuron sequencer; the FIN done-set comes last so it beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      ie      <= 1'b0;
      lsel    <= 1'b0;
      busy    <= 1'b0;
      in_ptr  <= '0;
      w_ptr   <= '0;
      out_idx <= '0;
      nrn     <= '0;
      step    <= '0;
      acc     <= '0;
      for (int i = 0; i < N_INPUTS; i++) in_mem[i] <= '0;
      for (int i = 0; i < HW_N; i++) hid_w[i] <= '0;
      for (int i = 0; i < OW_N; i++) out_w[i] <= '0;
      for (int i = 0; i < N_HIDDEN; i++) act[i] <= '0;
      for (int i = 0; i < N_OUTPUT; i++) res[i] <= '0;
    end else begin
      if (write_en && addr == 2'd0) begin
        lsel   <= writedata[3];
`ifdef MLP_IRQ_EN
        ie     <= writedata[2];
`endif
        in_ptr <= '0;
        w_ptr  <= '0;
        if (writedata[1] || (writedata[0] && !active)) done <= 1'b0;
        if (writedata[0] && !active) begin
          state <= HID;
          nrn   <= '0;
          step  <= '0;
        end
      end
      if (write_en && addr == 2'd1 && !active) begin
        in_mem[in_ptr] <= writedata[IN_WIDTH-1:0];
        in_ptr         <= in_ptr == IA'(N_INPUTS - 1) ? '0 : in_ptr + IA'(1);
      end
      if (write_en && addr == 2'd2 && !active) begin
        if (lsel) out_w[w_ptr[OWA-1:0]] <= writedata[WGT_WIDTH-1:0];
        else hid_w[w_ptr[HWA-1:0]] <= writedata[WGT_WIDTH-1:0];
        w_ptr <= (w_ptr == (lsel ? PW'(OW_N - 1) : PW'(HW_N - 1))) ? '0 : w_ptr + PW'(1);
      end
      if (write_en && addr == 2'd3) out_idx <= OA'(writedata % N_OUTPUT);
      case (state)
        HID, OUT: begin
          busy <= 1'b1;
          if (step == '0) begin
            acc  <= MAC_WIDTH'(wsel);
            step <= step + SC'(1);
          end else if (step <= kk) begin
            acc  <= acc + prod_ext;
            step <= step + SC'(1);
          end else begin
            if (hid) act[HA'(nrn)] <= y;
            else res[OA'(nrn)] <= y;
            step <= '0;
            nrn  <= last_n ? '0 : nrn + NC'(1);
            if (last_n) state <= hid ? OUT : FIN;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
  // registered read mux and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= addr == 2'd0 ? {27'd0, busy, lsel, ie, done, 1'b0} :
                  addr == 2'd1 ? 32'(in_ptr) :
                  addr == 2'd2 ? 32'(w_ptr) : 32'(res[out_idx]);
`ifdef MLP_IRQ_EN
      irq      <= done & ie;
`else
      irq      <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_mlp.sv
// tb_mlp: table-driven and randomized self-check of mlp against a plain-arithmetic network model
module tb_mlp;
  logic clk = 1'b0;
  logic rst, write_en, irq;
  logic [1:0] addr;
  logic [31:0] writedata, readdata;
  int tests = 0;
  int fails = 0;
`ifdef MLP_IRQ_EN
  localparam bit IEB = 1'b1;
`else
  localparam bit IEB = 1'b0;
`endif
  localparam int NV = 23;
  typedef struct packed {
    logic [0:1][31:0]  x;
    logic [0:11][31:0] hw;
    logic [0:4][31:0]  ow;
    logic [31:0]       osel;
    logic [31:0]       exp;
  } vec_t;
  vec_t tv [NV];
  mlp dut (.clk(clk), .rst(rst), .write_en(write_en), .addr(addr), .writedata(writedata), .readdata(readdata), .irq(irq));
  always #5 clk = ~clk;
  // runaway guard
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    write_en = 1'b1;
    addr = a;
    writedata = d;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    @(posedge clk);
    #1;
    v = readdata;
  endtask
  function automatic longint sat(input longint s);
    return s < 0 ? 64'sd0 : s > 32767 ? 64'sd32767 : s;
  endfunction
  function automatic int model(input vec_t v);
    longint a [4];
    longint s;
    for (int h = 0; h < 4; h++) begin
      s = longint'($signed(v.hw[h*3]));
      for (int i = 0; i < 2; i++) s += longint'($signed(v.hw[h*3+1+i])) * longint'($signed(v.x[i]));
      a[h] = sat(s);
    end
    s = longint'($signed(v.ow[0]));
    for (int h = 0; h < 4; h++) s += longint'($signed(v.ow[h+1])) * a[h];
    return int'(sat(s));
  endfunction
  function automatic int rnd(input bit big);
    logic [15:0] t;
    t = 16'($urandom);
    return big ? int'($signed(t)) : int'(t % 16'd201) - 100;
  endfunction
  task automatic load(input vec_t v);
    wr(2'd0, 32'h0);
    for (int i = 0; i < 2; i++) wr(2'd1, v.x[i]);
    for (int i = 0; i < 12; i++) wr(2'd2, v.hw[i]);
    wr(2'd0, 32'h8);
    for (int i = 0; i < 5; i++) wr(2'd2, v.ow[i]);
  endtask
  task automatic wait_done(input string name);
    logic [31:0] r;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      rd(2'd0, r);
      seen = r[1];
    end
    check(name, 64'(seen), 64'd1);
  endtask
  initial begin
    int nom_x [2] = '{7, -3};
    int nom_hw [12] = '{1, 2, 3, 0, -1, 2, -2, 4, 1, 1, 1, 1};
    int nom_exp [4] = '{6, 0, 23, 5};
    logic [31:0] r;
    logic [32:0] e;
    int seen_done, seen_irq;
    rst = 1'b1;
    write_en = 1'b0;
    addr = 2'd0;
    writedata = '0;
    // vector table: nominal, one-hot probes of each hidden activation, saturation, negative clamp, random
    for (int i = 0; i < NV; i++) tv[i] = '0;
    for (int i = 0; i < 2; i++) tv[0].x[i] = nom_x[i];
    for (int i = 0; i < 12; i++) tv[0].hw[i] = nom_hw[i];
    for (int i = 0; i < 5; i++) tv[0].ow[i] = 32'd1;
    tv[0].exp = 35;
    for (int j = 0; j < 4; j++) begin
      tv[j+1] = tv[0];
      tv[j+1].ow = '0;
      tv[j+1].ow[j+1] = 32'd1;
      tv[j+1].exp = nom_exp[j];
    end
    tv[5].x[0] = 1000;
    tv[5].hw[1] = 100;
    tv[5].ow[1] = 1;
    tv[5].exp = 32767;
    tv[6] = tv[0];
    tv[6].ow = '0;
    tv[6].ow[0] = -100;
    tv[6].exp = 0;
    for (int n = 7; n < NV; n++) begin
      for (int i = 0; i < 2; i++) tv[n].x[i] = rnd(n % 3 == 0);
      for (int i = 0; i < 12; i++) tv[n].hw[i] = rnd(n % 4 == 0);
      for (int i = 0; i < 5; i++) tv[n].ow[i] = rnd(n % 5 == 0);
      tv[n].osel = $urandom_range(0, 7);
      tv[n].exp = model(tv[n]);
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", 64'(readdata), 64'd0);
    check("reset_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), r);
      check($sformatf("reset_reg%0d", a), 64'(r), 64'd0);
    end
    // pointer wrap at layer boundaries
    wr(2'd1, 32'd11);
    rd(2'd1, r);
    check("in_ptr_one", 64'(r), 64'd1);
    wr(2'd1, 32'd22);
    rd(2'd1, r);
    check("in_ptr_wrap", 64'(r), 64'd0);
    for (int i = 0; i < 11; i++) wr(2'd2, 32'(i));
    rd(2'd2, r);
    check("hid_ptr_11", 64'(r), 64'd11);
    wr(2'd2, 32'd0);
    rd(2'd2, r);
    check("hid_ptr_wrap", 64'(r), 64'd0);
    wr(2'd0, 32'h8);
    for (int i = 0; i < 4; i++) wr(2'd2, 32'd0);
    rd(2'd2, r);
    check("out_ptr_4", 64'(r), 64'd4);
    wr(2'd2, 32'd0);
    rd(2'd2, r);
    check("out_ptr_wrap", 64'(r), 64'd0);
    rd(2'd0, r);
    check("ctrl_lsel", 64'(r), 64'h8);
    // table runs
    for (int n = 0; n < NV; n++) begin
      load(tv[n]);
      wr(2'd0, 32'h5);
      wait_done($sformatf("vec%0d_done", n));
      wr(2'd3, tv[n].osel);
      rd(2'd3, r);
      check($sformatf("vec%0d_out", n), 64'(r), 64'(tv[n].exp));
    end
    // timing: CTRL view lags internal state by one cycle through the registered readdata
    load(tv[0]);
    wr(2'd0, 32'h5);
    for (int k = 1; k <= 30; k++) begin
      write_en = 1'b0;
      addr = 2'd0;
      writedata = '0;
      if (k == 3) begin write_en = 1'b1; writedata = 32'h5; end
      else if (k == 4) begin write_en = 1'b1; addr = 2'd1; writedata = 32'h1234; end
      else if (k == 5) begin write_en = 1'b1; addr = 2'd2; writedata = 32'd1000; end
      else if (k == 6) addr = 2'd1;
      else if (k == 7) addr = 2'd2;
      else if (k == 23) begin write_en = 1'b1; writedata = 32'h6; end
      @(posedge clk);
      #1;
      write_en = 1'b0;
      e = {(k >= 24) && IEB, 27'd0, (k >= 2) && (k <= 23), 1'b0, IEB, k >= 24, 1'b0};
      if (k == 6) check("busy_in_ptr", 64'(readdata), 64'd0);
      else if (k == 7) check("busy_w_ptr", 64'(readdata), 64'd0);
      else if (k != 4 && k != 5) check($sformatf("ctrl_t%0d", k), 64'({irq, readdata}), 64'(e));
    end
    wr(2'd0, 32'h6);
    rd(2'd0, r);
    check("done_cleared", 64'(r), 64'({IEB, 2'b00}));
    check("irq_dropped", 64'(irq), 64'd0);
    rd(2'd3, r);
    check("busy_writes_ignored_out", 64'(r), 64'd35);
    // reset five cycles into a run
    wr(2'd0, 32'h5);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_readdata", 64'(readdata), 64'd0);
    rd(2'd0, r);
    check("midrst_ctrl", 64'(r), 64'd0);
    rd(2'd3, r);
    check("midrst_out", 64'(r), 64'd0);
    seen_done = 0;
    seen_irq = 0;
    for (int i = 0; i < 40; i++) begin
      rd(2'd0, r);
      if (r[1]) seen_done++;
      if (irq) seen_irq++;
    end
    check("midrst_no_done", 64'(seen_done), 64'd0);
    check("midrst_no_irq", 64'(seen_irq), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
